prof_result_slave: RTL and testbench

- Avalon-MM slave that terminates the profiler's Avalon profile master port.
- Holds a word-addressed on-chip buffer of profile words (function ranges / hash data in, counter results out).
- Serves pipelined reads with fixed latency and readdatavalid, bounds the number of outstanding reads via waitrequest, and accepts byte-enabled writes.
- Used in simulation and on-chip builds in place of SDRAM for the profile data region; exposes sticky status and traffic counters for the test harness.

---
 rtl/prof_result_slave_if.sv | 25 ++
 rtl/prof_result_slave.sv | 147 ++++++++++++++
 tb/tb_prof_result_slave.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/prof_result_slave_if.sv
// Avalon-MM profile port bundle between the profiler master and the result slave.
interface prof_result_slave_if;
    logic        avs_profileSlave_read;
    logic        avs_profileSlave_write;
    logic [31:0] avs_profileSlave_address;
    logic [31:0] avs_profileSlave_writedata;
    logic [3:0]  avs_profileSlave_byteenable;
    logic [31:0] avs_profileSlave_readdata;
    logic        avs_profileSlave_waitrequest;
    logic        avs_profileSlave_readdatavalid;

    modport master (
        output avs_profileSlave_read, avs_profileSlave_write, avs_profileSlave_address,
        output avs_profileSlave_writedata, avs_profileSlave_byteenable,
        input  avs_profileSlave_readdata, avs_profileSlave_waitrequest,
        input  avs_profileSlave_readdatavalid
    );

    modport slave (
        input  avs_profileSlave_read, avs_profileSlave_write, avs_profileSlave_address,
        input  avs_profileSlave_writedata, avs_profileSlave_byteenable,
        output avs_profileSlave_readdata, avs_profileSlave_waitrequest,
        output avs_profileSlave_readdatavalid
    );
endinterface

// File: rtl/prof_result_slave.sv
// On-chip profile buffer terminating the profiler's Avalon master: fixed-latency pipelined
// reads, bounded outstanding reads, byte-enabled writes. Define PROF_SLAVE_STALL_EN to inject periodic stalls.
module prof_result_slave #(
    parameter int          ADDR_W       = 10,
    parameter int          READ_LATENCY = 3,
    parameter int          MAX_PENDING  = 2,
    parameter int          STALL_PERIOD = 7,
    parameter logic [31:0] BAD_DATA     = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    prof_result_slave_if.slave   avs,
    output logic [15:0]          wr_count,
    output logic [15:0]          rd_count,
    output logic                 addr_error,
    output logic                 proto_error
);
    logic [31:0]       mem_q [2**ADDR_W];
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [31:0]       pipe_dat_q [READ_LATENCY];
    logic [31:0]       pipe_dat_d [READ_LATENCY];
    logic [3:0]        pending_q, pending_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic              addr_err_q, addr_err_d, proto_err_q, proto_err_d;
    logic              stall_s, wait_s, wr_acc_s, rd_acc_s, both_acc_s, oor_s, rdv_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [31:0]       rd_word_s;
    logic              unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^avs.avs_profileSlave_address[1:0];

`ifdef PROF_SLAVE_STALL_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;
    assign stall_s     = (stall_cnt_q == 8'(STALL_PERIOD - 1));
    assign stall_cnt_d = stall_s ? 8'd0 : stall_cnt_q + 8'd1;

    // Free-running stall-injection counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 8'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign stall_s = 1'b0;
`endif

    assign rdv_s      = pipe_vld_q[READ_LATENCY-1];
    assign wait_s     = reset | (avs.avs_profileSlave_read & (pending_q == 4'(MAX_PENDING))) | stall_s;
    assign wr_acc_s   = avs.avs_profileSlave_write & ~wait_s;
    assign both_acc_s = avs.avs_profileSlave_write & avs.avs_profileSlave_read & ~wait_s;
    // A simultaneous read is dropped in favour of the write.
    assign rd_acc_s   = avs.avs_profileSlave_read & ~avs.avs_profileSlave_write & ~wait_s;
    assign oor_s      = |avs.avs_profileSlave_address[31:ADDR_W+2];
    assign word_idx_s = avs.avs_profileSlave_address[ADDR_W+1:2];
    assign rd_word_s  = oor_s ? BAD_DATA : mem_q[word_idx_s];

    assign avs.avs_profileSlave_waitrequest   = wait_s;
    assign avs.avs_profileSlave_readdatavalid = rdv_s;
    assign avs.avs_profileSlave_readdata      = pipe_dat_q[READ_LATENCY-1];
    assign wr_count    = wr_cnt_q;
    assign rd_count    = rd_cnt_q;
    assign addr_error  = addr_err_q;
    assign proto_error = proto_err_q;

    // Next-state for read pipeline, pending count, traffic counters and sticky flags.
    always_comb begin
        pipe_vld_d  = pipe_vld_q;
        pipe_dat_d  = pipe_dat_q;
        pending_d   = pending_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        addr_err_d  = addr_err_q;
        proto_err_d = proto_err_q;

        // Data stages only load behind a valid so the last stage keeps the last returned word.
        pipe_vld_d[0] = rd_acc_s;
        pipe_dat_d[0] = rd_acc_s ? rd_word_s : pipe_dat_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dat_d[i] = pipe_vld_q[i-1] ? pipe_dat_q[i-1] : pipe_dat_q[i];
        end

        case ({rd_acc_s, rdv_s})
            2'b10:   pending_d = pending_q + 4'd1;
            2'b01:   pending_d = pending_q - 4'd1;
            default: pending_d = pending_q;
        endcase

        if (wr_acc_s && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        if (rd_acc_s && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end

        if ((wr_acc_s || rd_acc_s) && oor_s) begin
            addr_err_d = 1'b1;
        end else begin
            addr_err_d = addr_err_q;
        end
        if (both_acc_s) begin
            proto_err_d = 1'b1;
        end else begin
            proto_err_d = proto_err_q;
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat_q[i] <= 32'h0;
            end
            pending_q   <= 4'd0;
            wr_cnt_q    <= 16'd0;
            rd_cnt_q    <= 16'd0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_dat_q  <= pipe_dat_d;
            pending_q   <= pending_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            addr_err_q  <= addr_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Buffer storage; survives reset, writes are already blocked while reset holds waitrequest.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !oor_s) begin
            for (int b = 0; b < 4; b++) begin
                if (avs.avs_profileSlave_byteenable[b]) begin
                    mem_q[word_idx_s][b*8 +: 8] <= avs.avs_profileSlave_writedata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_prof_result_slave.sv
// Directed self-checking bench for prof_result_slave (default parameters).
module tb_prof_result_slave;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] wr_count, rd_count;
    logic        addr_error, proto_error;
    int          errors = 0;
    int          checks = 0;

    prof_result_slave_if bus ();

    prof_result_slave dut (
        .clk(clk), .reset(reset), .avs(bus.slave),
        .wr_count(wr_count), .rd_count(rd_count),
        .addr_error(addr_error), .proto_error(proto_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.avs_profileSlave_read       = 1'b0;
        bus.avs_profileSlave_write      = 1'b0;
        bus.avs_profileSlave_address    = 32'h0;
        bus.avs_profileSlave_writedata  = 32'h0;
        bus.avs_profileSlave_byteenable = 4'h0;
    endtask

    // Hold the command from a negedge until it is seen accepted, then release it at the next negedge.
    task automatic wait_accept(input string tag);
        int budget = 20;
        #1;
        while (bus.avs_profileSlave_waitrequest === 1'b1 && budget > 0) begin
            @(negedge clk); #1; budget--;
        end
        if (budget == 0) chk({tag, "_accept_timeout"}, 32'h1, 32'h0);
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.avs_profileSlave_write      = 1'b1;
        bus.avs_profileSlave_address    = a;
        bus.avs_profileSlave_writedata  = d;
        bus.avs_profileSlave_byteenable = be;
        wait_accept("wr");
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int n = 1;
        @(negedge clk);
        bus.avs_profileSlave_read    = 1'b1;
        bus.avs_profileSlave_address = a;
        wait_accept(tag);
        while (bus.avs_profileSlave_readdatavalid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_data"}, bus.avs_profileSlave_readdata, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    logic       exp_wait [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_rdv  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int         issued, returned, quiet;

    initial begin
        idle();
        @(negedge clk); @(negedge clk);
        chk("wait_in_reset", 32'(bus.avs_profileSlave_waitrequest), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_readdata", bus.avs_profileSlave_readdata, 32'h0);
        chk("rst_rdv", 32'(bus.avs_profileSlave_readdatavalid), 32'd0);
        chk("rst_wait", 32'(bus.avs_profileSlave_waitrequest), 32'd0);
        chk("rst_counts", {wr_count, rd_count}, 32'h0);
        chk("rst_flags", {30'd0, addr_error, proto_error}, 32'h0);

        // Basic write then read
        wr(32'h10, 32'h12345678, 4'hF);
        rd_check("t1", 32'h10, 32'h12345678);
        chk("t1_counts", {wr_count, rd_count}, {16'd1, 16'd1});

        // Byte-enabled merge
        wr(32'h14, 32'hAABBCCDD, 4'hF);
        wr(32'h14, 32'h00001100, 4'b0010);
        rd_check("t2", 32'h14, 32'hAABB11DD);

        // Four back-to-back reads against a pending limit of two
        for (int i = 0; i < 4; i++) wr(32'h40 + 32'(i*4), 32'hA0000000 + 32'(i), 4'hF);
        chk("t3_pre_counts", {wr_count, rd_count}, {16'd7, 16'd2});
        issued = 0; returned = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.avs_profileSlave_read    = (issued < 4);
            bus.avs_profileSlave_address = 32'h40 + 32'(issued*4);
            #1;
            if (c < 6) chk($sformatf("t3_wait_c%0d", c), 32'(bus.avs_profileSlave_waitrequest), 32'(exp_wait[c]));
            chk($sformatf("t3_rdv_c%0d", c), 32'(bus.avs_profileSlave_readdatavalid), 32'(exp_rdv[c]));
            if (bus.avs_profileSlave_readdatavalid === 1'b1) begin
                chk($sformatf("t3_data%0d", returned), bus.avs_profileSlave_readdata, 32'hA0000000 + 32'(returned));
                returned++;
            end
            if (bus.avs_profileSlave_read && !bus.avs_profileSlave_waitrequest) issued++;
        end
        idle();
        chk("t3_rd_count", {16'd0, rd_count}, 32'd6);

        // Out-of-range read and write
        wr(32'h0, 32'h0BADF00D, 4'hF);
        chk("t4_addr_err_clear", 32'(addr_error), 32'd0);
        rd_check("t4_oor", 32'h1000, 32'hDEADBEEF);
        chk("t4_addr_err", 32'(addr_error), 32'd1);
        wr(32'h1000, 32'hFFFFFFFF, 4'hF);
        rd_check("t4_alias", 32'h0, 32'h0BADF00D);
        chk("t4_counts", {wr_count, rd_count}, {16'd9, 16'd8});

        // Read and write together: write wins, read dropped
        chk("t5_proto_clear", 32'(proto_error), 32'd0);
        @(negedge clk);
        bus.avs_profileSlave_read       = 1'b1;
        bus.avs_profileSlave_write      = 1'b1;
        bus.avs_profileSlave_address    = 32'h20;
        bus.avs_profileSlave_writedata  = 32'd5;
        bus.avs_profileSlave_byteenable = 4'hF;
        wait_accept("t5");
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.avs_profileSlave_readdatavalid === 1'b1) quiet++;
            @(negedge clk);
        end
        chk("t5_no_rdv", 32'(quiet), 32'd0);
        chk("t5_proto", 32'(proto_error), 32'd1);
        chk("t5_counts", {wr_count, rd_count}, {16'd10, 16'd8});
        rd_check("t5_word8", 32'h20, 32'd5);

        // Reset the cycle after a read accept
        @(negedge clk);
        bus.avs_profileSlave_read    = 1'b1;
        bus.avs_profileSlave_address = 32'h20;
        #1;
        chk("t6_accept", 32'(bus.avs_profileSlave_waitrequest), 32'd0);
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.avs_profileSlave_readdatavalid === 1'b1) quiet++;
            @(negedge clk);
        end
        chk("t6_no_rdv", 32'(quiet), 32'd0);
        chk("t6_counts", {wr_count, rd_count}, 32'h0);
        chk("t6_flags", {30'd0, addr_error, proto_error}, 32'h0);
        chk("t6_readdata", bus.avs_profileSlave_readdata, 32'h0);
        // Pending cleared: two reads go straight in
        bus.avs_profileSlave_read    = 1'b1;
        bus.avs_profileSlave_address = 32'h20;
        #1;
        chk("t6_pend_a", 32'(bus.avs_profileSlave_waitrequest), 32'd0);
        @(negedge clk); #1;
        chk("t6_pend_b", 32'(bus.avs_profileSlave_waitrequest), 32'd0);
        @(negedge clk);
        idle();
        @(negedge clk); #1;
        chk("t6_word8", bus.avs_profileSlave_readdata, 32'd5);
        @(negedge clk); @(negedge clk);
        rd_check("t6_word8_again", 32'h20, 32'd5);

`ifdef PROF_SLAVE_STALL_EN
        // Continuous writes with periodic stall
        do_reset();
        issued = 0;
        for (int c = 0; c < 40 && issued < 20; c++) begin
            if (c > 0) @(negedge clk);
            bus.avs_profileSlave_write      = 1'b1;
            bus.avs_profileSlave_address    = 32'h100 + 32'(issued*4);
            bus.avs_profileSlave_writedata  = 32'(issued);
            bus.avs_profileSlave_byteenable = 4'hF;
            #1;
            chk($sformatf("t7_stall_c%0d", c), 32'(bus.avs_profileSlave_waitrequest), 32'((c % 7) == 6));
            if (!bus.avs_profileSlave_waitrequest) issued++;
        end
        @(negedge clk);
        idle();
        chk("t7_wr_count", {16'd0, wr_count}, 32'd20);
        rd_check("t7_last", 32'h100 + 32'd76, 32'd19);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
